// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: request/grant/response bus handshake,
// load alignment/extension, registered writeback and upstream stall.
// Ports: clk_i, rst_i (async, active-high); m_* M-stage inputs;
//   stall_o; dmem_* data memory bus; w_valid_o/w_data_o writeback;
//   misalign_o and bus_err_o single-cycle event pulses.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m_valid_i,
    input  logic [1:0]  m_mem_op_i,
    input  logic [1:0]  m_size_i,
    input  logic        m_unsigned_i,
    input  logic [31:0] m_alu_data_i,
    input  logic [31:0] m_store_data_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        w_valid_o,
    output logic [31:0] w_data_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      w_data_q, w_data_d;
    logic [3:0]       be_q, be_d;
    logic [1:0]       size_q, size_d;
    logic [1:0]       off_q, off_d;
    logic             we_q, we_d;
    logic             uns_q, uns_d;
    logic             w_valid_q, w_valid_d;
    logic             mis_q, mis_d;
    logic             err_q, err_d;

    logic        is_load, is_store, misaligned, expire;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] shifted;
    logic [31:0] load_val;

    assign is_load  = (m_mem_op_i == 2'b01);
    assign is_store = (m_mem_op_i == 2'b10);
    assign expire   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // Size decode for the incoming access; 2'b11 behaves as word.
    always_comb begin
        misaligned = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = m_store_data_i;
        unique case (1'b1)
            (m_size_i == 2'b00): begin
                be_calc    = 4'b0001 << m_alu_data_i[1:0];
                wdata_calc = {4{m_store_data_i[7:0]}};
            end
            (m_size_i == 2'b01): begin
                misaligned = m_alu_data_i[0];
                be_calc    = m_alu_data_i[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{m_store_data_i[15:0]}};
            end
            default: begin
                misaligned = (m_alu_data_i[1:0] != 2'b00);
            end
        endcase
    end

    // Load lane select and extension from the captured offset/size.
    assign shifted = dmem_rdata_i >> {off_q, 3'b000};

    always_comb begin
        load_val = shifted;
        unique case (1'b1)
            (size_q == 2'b00):
                load_val = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            (size_q == 2'b01):
                load_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default:
                load_val = shifted;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        we_d      = we_q;
        size_d    = size_q;
        off_d     = off_q;
        uns_d     = uns_q;
        w_data_d  = w_data_q;
        w_valid_d = 1'b0;
        mis_d     = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_valid_i) begin
                    if (!(is_load || is_store)) begin
                        w_valid_d = 1'b1;
                        w_data_d  = m_alu_data_i;
                    end else if (misaligned) begin
                        mis_d = 1'b1;
                    end else begin
                        addr_d  = {m_alu_data_i[31:2], 2'b00};
                        wdata_d = wdata_calc;
                        be_d    = be_calc;
                        we_d    = is_store;
                        size_d  = m_size_i;
                        off_d   = m_alu_data_i[1:0];
                        uns_d   = m_unsigned_i;
                        cnt_d   = '0;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                // A granted store is complete, so it beats expiry; a
                // granted load still owes its response and does not.
                if (dmem_gnt_i && we_q) begin
                    state_d = IDLE;
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (dmem_gnt_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_rvalid_i) begin
                    w_valid_d = 1'b1;
                    w_data_d  = load_val;
                    state_d   = IDLE;
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            size_q    <= '0;
            off_q     <= '0;
            uns_q     <= 1'b0;
            w_data_q  <= '0;
            w_valid_q <= 1'b0;
            mis_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            we_q      <= we_d;
            size_q    <= size_d;
            off_q     <= off_d;
            uns_q     <= uns_d;
            w_data_q  <= w_data_d;
            w_valid_q <= w_valid_d;
            mis_q     <= mis_d;
            err_q     <= err_d;
        end
    end

    assign stall_o      = (state_q != IDLE);
    assign dmem_req_o   = (state_q == REQ);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = wdata_q;
    assign w_valid_o    = w_valid_q;
    assign w_data_o     = w_data_q;
    assign misalign_o   = mis_q;
    assign bus_err_o    = err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu.
// Linear stimulus with hand-computed expectations; immediate assertions.
module tb_mem_stage_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m_valid_i;
    logic [1:0]  m_mem_op_i;
    logic [1:0]  m_size_i;
    logic        m_unsigned_i;
    logic [31:0] m_alu_data_i;
    logic [31:0] m_store_data_i;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        w_valid_o;
    logic [31:0] w_data_o;
    logic        misalign_o;
    logic        bus_err_o;

    int tests = 0;
    int fails = 0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .m_valid_i     (m_valid_i),
        .m_mem_op_i    (m_mem_op_i),
        .m_size_i      (m_size_i),
        .m_unsigned_i  (m_unsigned_i),
        .m_alu_data_i  (m_alu_data_i),
        .m_store_data_i(m_store_data_i),
        .stall_o       (stall_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .w_valid_o     (w_valid_o),
        .w_data_o      (w_data_o),
        .misalign_o    (misalign_o),
        .bus_err_o     (bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a,
                         input logic [31:0] d);
        m_valid_i      = 1'b1;
        m_mem_op_i     = op;
        m_size_i       = sz;
        m_unsigned_i   = uns;
        m_alu_data_i   = a;
        m_store_data_i = d;
        tick();
        m_valid_i = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
        chk({tag, "_req"}, {31'd0, dmem_req_o}, 32'd0);
        chk({tag, "_we"}, {31'd0, dmem_we_o}, 32'd0);
        chk({tag, "_addr"}, dmem_addr_o, 32'd0);
        chk({tag, "_be"}, {28'd0, dmem_be_o}, 32'd0);
        chk({tag, "_wdata"}, dmem_wdata_o, 32'd0);
        chk({tag, "_wvalid"}, {31'd0, w_valid_o}, 32'd0);
        chk({tag, "_wdata_o"}, w_data_o, 32'd0);
        chk({tag, "_mis"}, {31'd0, misalign_o}, 32'd0);
        chk({tag, "_err"}, {31'd0, bus_err_o}, 32'd0);
    endtask

    initial begin
        int stalls;
        rst_i          = 1'b1;
        m_valid_i      = 1'b0;
        m_mem_op_i     = 2'b00;
        m_size_i       = 2'b00;
        m_unsigned_i   = 1'b0;
        m_alu_data_i   = '0;
        m_store_data_i = '0;
        dmem_gnt_i     = 1'b0;
        dmem_rvalid_i  = 1'b0;
        dmem_rdata_i   = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst_i = 1'b0;
        tick();

        // pass-through, stray gnt/rvalid in IDLE ignored
        dmem_gnt_i    = 1'b1;
        dmem_rvalid_i = 1'b1;
        issue(2'b00, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0);
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        chk("pt_wvalid", {31'd0, w_valid_o}, 32'd1);
        chk("pt_wdata", w_data_o, 32'hDEADBEEF);
        chk("pt_stall", {31'd0, stall_o}, 32'd0);
        chk("pt_req", {31'd0, dmem_req_o}, 32'd0);
        tick();
        chk("pt_pulse", {31'd0, w_valid_o}, 32'd0);
        chk("pt_hold", w_data_o, 32'hDEADBEEF);

        // byte store, grant on the 4th REQ cycle
        issue(2'b10, 2'b00, 1'b0, 32'h00001002, 32'h000000A5);
        chk("bs_addr", dmem_addr_o, 32'h00001000);
        chk("bs_be", {28'd0, dmem_be_o}, 32'h4);
        chk("bs_wdata", dmem_wdata_o, 32'hA5A5A5A5);
        chk("bs_we", {31'd0, dmem_we_o}, 32'd1);
        stalls = 0;
        for (int i = 0; i < 3; i++) begin
            chk("bs_req", {31'd0, dmem_req_o}, 32'd1);
            stalls += int'(stall_o);
            tick();
        end
        chk("bs_addr_stable", dmem_addr_o, 32'h00001000);
        stalls += int'(stall_o);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        chk("bs_stalls", stalls, 32'd4);
        chk("bs_idle", {31'd0, stall_o}, 32'd0);
        chk("bs_req_low", {31'd0, dmem_req_o}, 32'd0);
        chk("bs_no_w", {31'd0, w_valid_o}, 32'd0);

        // signed half load, rvalid two cycles after gnt
        issue(2'b01, 2'b01, 1'b0, 32'h00002002, 32'h0);
        chk("hl_addr", dmem_addr_o, 32'h00002000);
        chk("hl_be", {28'd0, dmem_be_o}, 32'hC);
        chk("hl_we", {31'd0, dmem_we_o}, 32'd0);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        chk("hl_req_drop", {31'd0, dmem_req_o}, 32'd0);
        chk("hl_stall", {31'd0, stall_o}, 32'd1);
        tick();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h80011234;
        tick();
        dmem_rvalid_i = 1'b0;
        chk("hl_wvalid", {31'd0, w_valid_o}, 32'd1);
        chk("hl_wdata", w_data_o, 32'hFFFF8001);
        chk("hl_stall_drop", {31'd0, stall_o}, 32'd0);
        tick();
        chk("hl_pulse", {31'd0, w_valid_o}, 32'd0);

        // unsigned half load, rvalid right after gnt
        issue(2'b01, 2'b01, 1'b1, 32'h00002002, 32'h0);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        tick();
        dmem_rvalid_i = 1'b0;
        chk("hu_wdata", w_data_o, 32'h00008001);
        chk("hu_wvalid", {31'd0, w_valid_o}, 32'd1);

        // signed byte load from lane 3
        issue(2'b01, 2'b00, 1'b0, 32'h00003003, 32'h0);
        chk("bl_be", {28'd0, dmem_be_o}, 32'h8);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h7F000000;
        tick();
        dmem_rvalid_i = 1'b0;
        chk("bl_wdata", w_data_o, 32'h0000007F);

        // misaligned word and half
        issue(2'b01, 2'b10, 1'b0, 32'h00004001, 32'h0);
        chk("mw_mis", {31'd0, misalign_o}, 32'd1);
        chk("mw_req", {31'd0, dmem_req_o}, 32'd0);
        chk("mw_stall", {31'd0, stall_o}, 32'd0);
        chk("mw_wvalid", {31'd0, w_valid_o}, 32'd0);
        tick();
        chk("mw_pulse", {31'd0, misalign_o}, 32'd0);
        chk("mw_req2", {31'd0, dmem_req_o}, 32'd0);
        issue(2'b10, 2'b01, 1'b0, 32'h00005003, 32'h0);
        chk("mh_mis", {31'd0, misalign_o}, 32'd1);
        chk("mh_req", {31'd0, dmem_req_o}, 32'd0);

        // timeout: no grant for 16 REQ cycles
        issue(2'b10, 2'b10, 1'b0, 32'h00006000, 32'h11223344);
        chk("to_wdata", dmem_wdata_o, 32'h11223344);
        for (int i = 0; i < 15; i++) begin
            chk("to_req", {31'd0, dmem_req_o}, 32'd1);
            chk("to_no_err", {31'd0, bus_err_o}, 32'd0);
            tick();
        end
        chk("to_req_last", {31'd0, dmem_req_o}, 32'd1);
        tick();
        chk("to_err", {31'd0, bus_err_o}, 32'd1);
        chk("to_req_drop", {31'd0, dmem_req_o}, 32'd0);
        chk("to_stall", {31'd0, stall_o}, 32'd0);
        chk("to_no_w", {31'd0, w_valid_o}, 32'd0);
        tick();
        chk("to_pulse", {31'd0, bus_err_o}, 32'd0);

        // completion in the expiry cycle wins
        issue(2'b01, 2'b10, 1'b0, 32'h00008000, 32'h0);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("ce_stall", {31'd0, stall_o}, 32'd1);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h12345678;
        tick();
        dmem_rvalid_i = 1'b0;
        chk("ce_wvalid", {31'd0, w_valid_o}, 32'd1);
        chk("ce_wdata", w_data_o, 32'h12345678);
        chk("ce_no_err", {31'd0, bus_err_o}, 32'd0);

        // reset during RESP
        issue(2'b01, 2'b10, 1'b0, 32'h00007000, 32'h0);
        dmem_gnt_i = 1'b1;
        tick();
        dmem_gnt_i = 1'b0;
        chk("rr_stall", {31'd0, stall_o}, 32'd1);
        rst_i = 1'b1;
        #1;
        chk_all_zero("rr");
        tick();
        rst_i = 1'b0;
        dmem_rvalid_i = 1'b1;
        tick();
        dmem_rvalid_i = 1'b0;
        chk("rr_no_w", {31'd0, w_valid_o}, 32'd0);
        chk("rr_no_err", {31'd0, bus_err_o}, 32'd0);
        chk("rr_idle", {31'd0, stall_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
